// File: rtl/phv_queue_dispatch_pkg.sv
// Shared defaults and multicast-mode encodings
// for the PHV queue dispatch block.
package phv_queue_dispatch_pkg;

  localparam int DEF_PHV_LEN       = 1152;
  localparam int DEF_NUM_QUEUES    = 4;
  localparam int DEF_QUEUE_MAP_OFF = 141;
  localparam int DEF_CNT_WIDTH     = 32;

  localparam int MCAST_ATOMIC  = 0;
  localparam int MCAST_PARTIAL = 1;

endpackage

// File: rtl/phv_queue_dispatch_stat_cnt.sv
// Wrapping statistics counter; clear beats inc.
// Ports: axis_clk, aresetn, inc, clear -> cnt.
module dispatch_stat_cnt
  import phv_queue_dispatch_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/phv_queue_dispatch.sv
// PHV fan-out to per-queue FIFOs by queue mask.
// Ports: phv_in/valid/ready, phv_out/valid, fifo ready, stats.
module phv_queue_dispatch
  import phv_queue_dispatch_pkg::*;
#(
  parameter int PHV_LEN       = DEF_PHV_LEN,
  parameter int C_NUM_QUEUES  = DEF_NUM_QUEUES,
  parameter int QUEUE_MAP_OFF = DEF_QUEUE_MAP_OFF,
  parameter int MCAST_MODE    = MCAST_PARTIAL,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_in_valid,
  output logic                            phv_in_ready,
  output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
  output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
  input  logic [C_NUM_QUEUES-1:0]         phv_fifo_ready,
  input  logic                            cnt_clear,
  output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] cnt_out,
  output logic [CNT_WIDTH-1:0]            cnt_drop
);

  logic                    busy_d, busy_q;
  logic [PHV_LEN-1:0]      hold_d, hold_q;
  logic [C_NUM_QUEUES-1:0] pending_d, pending_q;

  logic [C_NUM_QUEUES-1:0] in_mask;
  logic [C_NUM_QUEUES-1:0] blocked;
  logic [C_NUM_QUEUES-1:0] grant;
  logic [C_NUM_QUEUES-1:0] out_vld;
  logic [C_NUM_QUEUES-1:0] left;
  logic                    done;
  logic                    in_ready;
  logic                    accept;
  logic                    drop_inc;

  assign in_mask = phv_in[QUEUE_MAP_OFF +: C_NUM_QUEUES];

  // Partial mode serves each ready target as it comes;
  // atomic mode waits until every remaining target is ready.
  always_comb begin
    blocked = pending_q & ~phv_fifo_ready;
    grant   = '0;
    out_vld = '0;
    if (MCAST_MODE == MCAST_PARTIAL) begin
      grant   = {C_NUM_QUEUES{busy_q}} & pending_q
              & phv_fifo_ready;
      out_vld = {C_NUM_QUEUES{busy_q}} & pending_q;
    end else begin
      if (busy_q && (blocked == '0))
        grant = pending_q;
      out_vld = grant;
    end
  end

  assign left     = pending_q & ~grant;
  assign done     = busy_q & (left == '0);
  assign in_ready = ~busy_q | done;
  assign accept   = phv_in_valid & in_ready;
  assign drop_inc = accept & (in_mask == '0);

  always_comb begin
    busy_d    = busy_q;
    hold_d    = hold_q;
    pending_d = left;
    if (done)
      busy_d = 1'b0;
    if (accept && (in_mask != '0)) begin
      busy_d    = 1'b1;
      hold_d    = phv_in;
      pending_d = in_mask;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      busy_q    <= 1'b0;
      hold_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
    end
  end

  assign phv_in_ready  = in_ready;
  assign phv_out_valid = out_vld;
  assign phv_out       = {C_NUM_QUEUES{hold_q}};

  for (genvar gi = 0; gi < C_NUM_QUEUES; gi++) begin : g_q_cnt
    dispatch_stat_cnt #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .axis_clk(axis_clk),
      .aresetn (aresetn),
      .inc     (grant[gi]),
      .clear   (cnt_clear),
      .cnt     (cnt_out[gi*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  dispatch_stat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_drop_cnt (
    .axis_clk(axis_clk),
    .aresetn (aresetn),
    .inc     (drop_inc),
    .clear   (cnt_clear),
    .cnt     (cnt_drop)
  );

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Directed bench: partial-mode DUT (a) and
// atomic-mode DUT (b) driven from one vector table.
module tb_phv_queue_dispatch;

  localparam int PL   = 1152;
  localparam int NQ   = 4;
  localparam int QOFF = 141;
  localparam int CW   = 32;

  logic axis_clk = 1'b0;
  logic aresetn;
  always #5 axis_clk = ~axis_clk;

  logic [PL-1:0]    a_in, b_in;
  logic             a_vld, b_vld;
  logic             a_rdy, b_rdy;
  logic [NQ*PL-1:0] a_out, b_out;
  logic [NQ-1:0]    a_ov, b_ov;
  logic [NQ-1:0]    a_fr, b_fr;
  logic             a_clr, b_clr;
  logic [NQ*CW-1:0] a_cnt, b_cnt;
  logic [CW-1:0]    a_drop, b_drop;

  phv_queue_dispatch #(
    .PHV_LEN(PL), .C_NUM_QUEUES(NQ),
    .QUEUE_MAP_OFF(QOFF), .MCAST_MODE(1),
    .CNT_WIDTH(CW)
  ) dut_a (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .phv_in(a_in), .phv_in_valid(a_vld),
    .phv_in_ready(a_rdy), .phv_out(a_out),
    .phv_out_valid(a_ov), .phv_fifo_ready(a_fr),
    .cnt_clear(a_clr), .cnt_out(a_cnt),
    .cnt_drop(a_drop)
  );

  phv_queue_dispatch #(
    .PHV_LEN(PL), .C_NUM_QUEUES(NQ),
    .QUEUE_MAP_OFF(QOFF), .MCAST_MODE(0),
    .CNT_WIDTH(CW)
  ) dut_b (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .phv_in(b_in), .phv_in_valid(b_vld),
    .phv_in_ready(b_rdy), .phv_out(b_out),
    .phv_out_valid(b_ov), .phv_fifo_ready(b_fr),
    .cnt_clear(b_clr), .cnt_out(b_cnt),
    .cnt_drop(b_drop)
  );

  typedef struct {
    bit          b;
    logic        vld;
    logic [3:0]  mask;
    logic [3:0]  rdy;
    logic [3:0]  ev;
    logic        er;
    logic [PL-1:0] data;
    logic [PL-1:0] edata;
  } vec_t;

  vec_t          tv[$];
  logic [PL-1:0] held[2];
  logic [PL-1:0] sp[100];
  int            n_checks = 0;
  int            n_err    = 0;

  function automatic logic [PL-1:0] mk_phv(
    input logic [3:0] mask);
    logic [PL-1:0] p;
    for (int w = 0; w < PL / 32; w++)
      p[w*32 +: 32] = $urandom;
    p[QOFF +: NQ] = mask;
    return p;
  endfunction

  function automatic void add(
    input bit b, input logic vld,
    input logic [3:0] mask, input logic [3:0] rdy,
    input logic [3:0] ev, input logic er);
    vec_t v;
    v.b = b; v.vld = vld; v.mask = mask;
    v.rdy = rdy; v.ev = ev; v.er = er;
    v.data  = vld ? mk_phv(mask) : '0;
    v.edata = held[b];
    if (vld && mask != 4'd0)
      held[b] = v.data;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
        nm, act, exp);
    end
  endtask

  task automatic chk_phv(input string nm,
    input logic [PL-1:0] act, input logic [PL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ..%h expected ..%h",
        nm, act[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk_cnts(input string nm,
    input logic [NQ*CW-1:0] cnt, input logic [CW-1:0] drop,
    input int e0, input int e1, input int e2,
    input int e3, input int ed);
    chk({nm, " cnt0"}, 64'(cnt[0*CW +: CW]), 64'(e0));
    chk({nm, " cnt1"}, 64'(cnt[1*CW +: CW]), 64'(e1));
    chk({nm, " cnt2"}, 64'(cnt[2*CW +: CW]), 64'(e2));
    chk({nm, " cnt3"}, 64'(cnt[3*CW +: CW]), 64'(e3));
    chk({nm, " drop"}, 64'(drop), 64'(ed));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [3:0] em;
    held[0] = '0;
    held[1] = '0;

    // unicast on a
    add(0, 1, 4'b0100, 4'b1111, 4'b0000, 1);
    add(0, 0, 4'b0000, 4'b1111, 4'b0100, 1);
    add(0, 0, 4'b0000, 4'b1111, 4'b0000, 1);
    // partial multicast on a
    add(0, 1, 4'b1011, 4'b0001, 4'b0000, 1);
    add(0, 0, 4'b0000, 4'b0001, 4'b1011, 0);
    add(0, 0, 4'b0000, 4'b0001, 4'b1010, 0);
    add(0, 0, 4'b0000, 4'b0001, 4'b1010, 0);
    add(0, 0, 4'b0000, 4'b1111, 4'b1010, 1);
    add(0, 0, 4'b0000, 4'b1111, 4'b0000, 1);
    // empty-mask drops on a
    for (int i = 0; i < 5; i++)
      add(0, 1, 4'b0000, 4'b1111, 4'b0000, 1);
    add(0, 0, 4'b0000, 4'b1111, 4'b0000, 1);
    // atomic multicast on b
    add(1, 1, 4'b0011, 4'b0000, 4'b0000, 1);
    add(1, 0, 4'b0000, 4'b0001, 4'b0000, 0);
    add(1, 0, 4'b0000, 4'b0010, 4'b0000, 0);
    add(1, 0, 4'b0000, 4'b0001, 4'b0000, 0);
    add(1, 0, 4'b0000, 4'b0011, 4'b0011, 1);
    add(1, 0, 4'b0000, 4'b1111, 4'b0000, 1);

    aresetn = 1'b0;
    a_in = '0; a_vld = 0; a_fr = '0; a_clr = 0;
    b_in = '0; b_vld = 0; b_fr = '0; b_clr = 0;
    repeat (3) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("rst a ready", 64'(a_rdy), 64'd1);
    chk("rst a valid", 64'(a_ov), 64'd0);
    chk("rst b ready", 64'(b_rdy), 64'd1);
    chk("rst b valid", 64'(b_ov), 64'd0);
    chk_phv("rst a phv_out", a_out[PL-1:0], '0);
    chk_cnts("rst a", a_cnt, a_drop, 0, 0, 0, 0, 0);
    tick();

    foreach (tv[k]) begin
      a_vld = 0; a_in = '0; a_fr = '0;
      b_vld = 0; b_in = '0; b_fr = '0;
      if (tv[k].b) begin
        b_vld = tv[k].vld; b_in = tv[k].data;
        b_fr = tv[k].rdy;
      end else begin
        a_vld = tv[k].vld; a_in = tv[k].data;
        a_fr = tv[k].rdy;
      end
      #1;
      chk($sformatf("vec%0d valid", k),
        64'(tv[k].b ? b_ov : a_ov), 64'(tv[k].ev));
      chk($sformatf("vec%0d ready", k),
        64'(tv[k].b ? b_rdy : a_rdy), 64'(tv[k].er));
      for (int i = 0; i < NQ; i++)
        if (tv[k].ev[i])
          chk_phv($sformatf("vec%0d data q%0d", k, i),
            tv[k].b ? b_out[i*PL +: PL]
                    : a_out[i*PL +: PL],
            tv[k].edata);
      tick();
    end
    a_vld = 0; a_fr = '0; b_vld = 0; b_fr = '0;
    #1;
    chk_cnts("tbl a", a_cnt, a_drop, 1, 1, 1, 1, 5);
    chk_cnts("tbl b", b_cnt, b_drop, 1, 1, 0, 0, 0);

    // clear coincident with a grant on q0
    a_vld = 1; a_in = mk_phv(4'b0001); a_fr = 4'b1111;
    tick();
    a_vld = 0; a_clr = 1;
    #1;
    chk("clr grant valid", 64'(a_ov), 64'b0001);
    tick();
    a_clr = 0;
    chk_cnts("clr a", a_cnt, a_drop, 0, 0, 0, 0, 0);

    // back-to-back streaming, round-robin masks
    for (int k = 0; k < 100; k++)
      sp[k] = mk_phv(4'(1 << (k % 4)));
    acc = 0;
    for (int k = 0; k <= 100; k++) begin
      a_vld = (k < 100);
      a_in  = (k < 100) ? sp[k] : '0;
      a_fr  = 4'b1111;
      #1;
      chk($sformatf("strm%0d ready", k),
        64'(a_rdy), 64'd1);
      if (a_vld && a_rdy) acc++;
      if (k > 0) begin
        em = 4'(1 << ((k - 1) % 4));
        chk($sformatf("strm%0d valid", k),
          64'(a_ov), 64'(em));
        for (int i = 0; i < NQ; i++)
          if (em[i])
            chk_phv($sformatf("strm%0d data", k),
              a_out[i*PL +: PL], sp[k-1]);
      end
      tick();
    end
    a_vld = 0;
    chk("strm accepts", 64'(acc), 64'd100);
    chk_cnts("strm a", a_cnt, a_drop, 25, 25, 25, 25, 0);

    // reset while q3 is pending and stalled
    a_vld = 1; a_in = mk_phv(4'b1000); a_fr = 4'b0000;
    tick();
    a_vld = 0; a_in = '0;
    #1;
    chk("stall valid", 64'(a_ov), 64'b1000);
    chk("stall ready", 64'(a_rdy), 64'd0);
    aresetn = 1'b0;
    @(posedge axis_clk);
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    a_fr = 4'b1111;
    #1;
    chk("rst2 valid", 64'(a_ov), 64'd0);
    chk("rst2 ready", 64'(a_rdy), 64'd1);
    chk_phv("rst2 phv_out", a_out[3*PL +: PL], '0);
    chk_cnts("rst2 a", a_cnt, a_drop, 0, 0, 0, 0, 0);
    tick();
    chk("rst2 no redeliver", 64'(a_ov), 64'd0);
    chk("rst2 cnt3", 64'(a_cnt[3*CW +: CW]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_err);
    $finish;
  end

endmodule
